// File: rtl/core_run_ctrl_if.sv
// core_run_ctrl_if: bundles the host-side run request/result signals and the
// core-side control/observation pins of the run controller.
//   slave  modport: used by core_run_ctrl.
//   master modport: used by the harness that drives start and models the core.
// Signals:
//   start, fin_addr, max_cycles      : run request (host -> controller)
//   pc, rf_rdata                     : core observation (core -> controller)
//   core_reset, core_en, rf_raddr    : core control (controller -> core)
//   busy, done, hit, timeout, cycles,
//   a0_val, sp_val                   : run status/result (controller -> host)
interface core_run_ctrl_if #(
    parameter int unsigned CYC_W = 16
);
    logic             start;
    logic [31:0]      fin_addr;
    logic [CYC_W-1:0] max_cycles;
    logic [31:0]      pc;
    logic [31:0]      rf_rdata;
    logic             core_reset;
    logic             core_en;
    logic [4:0]       rf_raddr;
    logic             busy;
    logic             done;
    logic             hit;
    logic             timeout;
    logic [CYC_W-1:0] cycles;
    logic [31:0]      a0_val;
    logic [31:0]      sp_val;

    modport slave (
        input  start, fin_addr, max_cycles, pc, rf_rdata,
        output core_reset, core_en, rf_raddr,
        output busy, done, hit, timeout, cycles, a0_val, sp_val
    );

    modport master (
        output start, fin_addr, max_cycles, pc, rf_rdata,
        input  core_reset, core_en, rf_raddr,
        input  busy, done, hit, timeout, cycles, a0_val, sp_val
    );
endinterface

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: sequences one program run on the single-cycle core.
// Holds the core in reset for HOLD_CYCLES cycles, runs it while counting
// cycles, stops on PC == fin_addr or budget expiry, then reads x10 and x2
// through the register-file debug port and holds the results.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-low
//   ctrl  : core_run_ctrl_if.slave (request, core pins, results)
module core_run_ctrl #(
    parameter int unsigned CYC_W       = 16,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    core_run_ctrl_if.slave  ctrl
);
    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_RD_A0,
        S_RD_SP,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_nxt;
    logic [31:0]      r_fin;
    logic [CYC_W-1:0] r_max;
    logic [CYC_W-1:0] r_cycles;
    logic [HW-1:0]    r_hold;
    logic             r_core_reset;
    logic             r_core_en;
    logic [4:0]       r_raddr;
    logic             r_busy;
    logic             r_done;
    logic             r_hit;
    logic             r_timeout;
    logic [31:0]      r_a0;
    logic [31:0]      r_sp;

    logic [CYC_W-1:0] w_cyc_inc;
    logic             w_pc_hit;
    logic             w_budget;
    logic             w_start;

    assign w_cyc_inc = r_cycles + CYC_W'(1);
    assign w_pc_hit  = (ctrl.pc == r_fin);
    // Budget compares against the count this cycle will produce, so a budget
    // of M ends the run after exactly M RUN cycles.
    assign w_budget  = (r_max != '0) && (w_cyc_inc == r_max);
    assign w_start   = ctrl.start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (w_start) w_nxt = S_HOLD;
            S_HOLD:         if (r_hold == '0) w_nxt = S_RUN;
            S_RUN:          if (w_pc_hit || w_budget) w_nxt = S_RD_A0;
            S_RD_A0:        w_nxt = S_RD_SP;
            S_RD_SP:        w_nxt = S_DONE;
            default:        w_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with r_state
    // without any combinational path from start.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_fin        <= '0;
            r_max        <= '0;
            r_cycles     <= '0;
            r_hold       <= '0;
            r_core_reset <= 1'b1;
            r_core_en    <= 1'b0;
            r_raddr      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_hit        <= 1'b0;
            r_timeout    <= 1'b0;
            r_a0         <= '0;
            r_sp         <= '0;
        end else begin
            r_state      <= w_nxt;
            r_core_reset <= (w_nxt == S_IDLE) || (w_nxt == S_HOLD);
            r_core_en    <= (w_nxt == S_HOLD) || (w_nxt == S_RUN);
            r_raddr      <= (w_nxt == S_RD_A0) ? 5'd10 :
                            (w_nxt == S_RD_SP) ? 5'd2  : 5'd0;
            r_busy       <= (w_nxt == S_HOLD) || (w_nxt == S_RUN) ||
                            (w_nxt == S_RD_A0) || (w_nxt == S_RD_SP);
            r_done       <= (w_nxt == S_DONE);

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_fin     <= ctrl.fin_addr;
                        r_max     <= ctrl.max_cycles;
                        r_cycles  <= '0;
                        r_hit     <= 1'b0;
                        r_timeout <= 1'b0;
                        r_a0      <= '0;
                        r_sp      <= '0;
                        r_hold    <= HW'(HOLD_CYCLES - 1);
                    end
                end
                S_HOLD: begin
                    if (r_hold != '0) r_hold <= r_hold - HW'(1);
                end
                S_RUN: begin
                    r_cycles <= (&r_cycles) ? r_cycles : w_cyc_inc;
                    // PC match takes priority over simultaneous budget expiry.
                    if (w_pc_hit)      r_hit     <= 1'b1;
                    else if (w_budget) r_timeout <= 1'b1;
                end
                S_RD_A0: r_a0 <= ctrl.rf_rdata;
                S_RD_SP: r_sp <= ctrl.rf_rdata;
                default: ;
            endcase
        end
    end

    assign ctrl.core_reset = r_core_reset;
    assign ctrl.core_en    = r_core_en;
    assign ctrl.rf_raddr   = r_raddr;
    assign ctrl.busy       = r_busy;
    assign ctrl.done       = r_done;
    assign ctrl.hit        = r_hit;
    assign ctrl.timeout    = r_timeout;
    assign ctrl.cycles     = r_cycles;
    assign ctrl.a0_val     = r_a0;
    assign ctrl.sp_val     = r_sp;
endmodule

// File: doc/core_run_ctrl.md
# core_run_ctrl

Run controller that sequences one program execution on the single-cycle RISC-V core. It holds the core in reset and then releases it, and counts execution cycles against a budget. It stops the core when the PC reaches a programmed end address or the budget expires, then reads a0 (x10) and sp (x2) through a register-file debug read port. It sits between the core's clock-enable/reset/PC/debug-read pins and a host or regression harness that issues `start` and collects the result.

## Interface
- `CYC_W`, default 16: width of cycle budget and cycle counter.
- `HOLD_CYCLES`, default 2: cycles the core is held in reset before running (≥1).
- `clk`  in  1: single clock; all state changes on rising edge.
- `reset`  in  1: synchronous, active-low; sampled on the rising edge of `clk`.
- `start`  in  1: request one run; sampled only in IDLE and DONE.
- `fin_addr`  in  32: PC value that marks program end; sampled when `start` is accepted.
- `max_cycles`  in  CYC_W: RUN-cycle budget; 0 = unlimited; sampled when `start` is accepted.
- `pc`  in  32: core program counter.
- `rf_rdata`  in  32: core register-file debug read data, combinational from `rf_raddr`.
- `core_reset`  out  1: active-high reset to the core.
- `core_en`  out  1: clock enable to the core (PC and register-file writes).
- `rf_raddr`  out  5: debug read address.
- `busy`  out  1: high in HOLD, RUN, RD_A0, RD_SP.
- `done`  out  1: high in DONE.
- `hit`  out  1: run ended by PC match.
- `timeout`  out  1: run ended by budget expiry.
- `cycles`  out  CYC_W: RUN cycles consumed.
- `a0_val`, `sp_val`  out  32: captured x10 and x2.

## Operation
- States: IDLE, HOLD, RUN, RD_A0, RD_SP, DONE. Outputs are decoded from registered state; no output depends combinationally on `start`.
- IDLE: `core_reset`=1, `core_en`=0. If `start`=1, latch `fin_addr` and `max_cycles`, clear `cycles`, `hit`, `timeout`, `a0_val`, `sp_val`, load the hold counter, and go to HOLD.
- HOLD: `core_reset`=1, `core_en`=1. Stay exactly HOLD_CYCLES cycles, then go to RUN.
- RUN: `core_reset`=0, `core_en`=1, and `cycles` increments each cycle, saturating at all-ones. Each cycle, evaluate in this priority:
  - `pc`==latched fin → set `hit`=1, go to RD_A0.
  - latched max≠0 and `cycles`+1 == max → set `timeout`=1, go to RD_A0.
  - otherwise stay in RUN.
- On the exit edge the core is still enabled, so the instruction at `fin_addr` executes once. Programs end in a self-loop (`j .`), so this is harmless.
- RD_A0: `core_en`=0, `core_reset`=0, `rf_raddr`=10. Capture `rf_rdata` into `a0_val`, then go to RD_SP.
- RD_SP: `rf_raddr`=2. Capture into `sp_val`, then go to DONE.
- DONE: `core_en`=0 and `core_reset`=0, so core state stays frozen and readable. Results are held. `start`=1 starts a new run exactly as from IDLE, with the core reset again in HOLD.
- `start` in HOLD, RUN, RD_A0 or RD_SP is ignored (not queued).
- `rf_raddr`=0 in all states other than RD_A0 and RD_SP.
- `hit` and `timeout` are mutually exclusive. Simultaneous match and budget expiry → `hit`=1, `timeout`=0.

## Timing
- Reset (`reset`=0 at an edge) from any state → IDLE. Reset values:
  - `core_reset`=1, `core_en`=0, `rf_raddr`=0.
  - `busy`=0, `done`=0, `hit`=0, `timeout`=0.
  - `cycles`=0, `a0_val`=0, `sp_val`=0.
- Reset mid-run aborts with no capture.
- Latency from `start` edge to first RUN cycle = HOLD_CYCLES+1 edges.
- If the PC match occurs in RUN cycle N (1-based), then `cycles`=N and `done` rises 3 edges after the match edge (RD_A0, RD_SP, DONE).
- With a budget of M, the run ends after exactly M RUN cycles, with `cycles`=M.
- `busy` and `done` are never high together; exactly one of IDLE/busy/DONE holds.

## Test plan
- Cipher program, `fin_addr`=0xBC, `max_cycles`=50000 → `hit`=1, `timeout`=0, `a0_val`=0x00fff05f, `sp_val`=0x00100000, `done`=1, `busy`=0.
- Program that never reaches `fin_addr`=0x100, `max_cycles`=100 → `timeout`=1, `hit`=0, `cycles`=100, `core_en`=0 from the edge after RUN cycle 100.
- Model `pc` reaching `fin_addr` in RUN cycle 5 with `max_cycles`=5 → `hit`=1, `timeout`=0, `cycles`=5.
- `max_cycles`=0, `pc` match after 3000 cycles → no timeout, `hit`=1, `cycles`=3000.
- `start` pulsed during RUN → ignored, with `cycles`/result unchanged. Then `start` in DONE → HOLD for 2 cycles with `core_reset`=1, and results cleared.
- `reset`=0 mid-RUN at cycle 10 → next edge IDLE, `core_reset`=1, all outputs at reset values. `start` afterwards runs normally.
